vx_fp_divsqrt_arb: RTL and testbench
====================================

VX_FP_DIVSQRT_ARB -- requirements
Module: VX_fp_divsqrt_arb

Interface
REQ-001 SHALL have parameter TAGW, default 1: width of the request tag carried with each result.
REQ-002 SHALL have parameter LANES, default 1: number of 32-bit lanes per result.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset; sampled on clk; reset==0 resets the block.
REQ-005 SHALL have ports valid_in0, input, 1, and ready_in0, output, 1: handshake for port 0, the divider result stream.
REQ-006 SHALL have ports tag_in0 [TAGW], result_in0 [LANES*32], has_fflags_in0 [1] and fflags_in0 [LANES*5], all input: payload for port 0.
REQ-007 SHALL have ports valid_in1, ready_in1, tag_in1, result_in1, has_fflags_in1 and fflags_in1, with the same directions and widths as port 0: handshake and payload for port 1, the square-root result stream.
REQ-008 SHALL have ports valid_out, output, 1, and ready_out, input, 1: merged response handshake.
REQ-009 SHALL have ports tag_out [TAGW], result [LANES*32], has_fflags [1] and fflags [LANES*5], all output: merged response payload.
REQ-010 SHALL have port src_out, output, 1: index (0 or 1) of the input port that produced the head entry.

Function
REQ-011 SHALL buffer responses in an internal 2-entry FIFO (count 0..2); each entry holds {src, tag, result, has_fflags, fflags}.
REQ-012 SHALL compute ready_in0/ready_in1 only from registered state (count, prio) and the valid inputs; ready SHALL NOT depend combinationally on ready_out.
REQ-013 SHALL grant no input while count==2; this holds even when a pop occurs in the same cycle.
REQ-014 SHALL, when count<2 and exactly one valid_inX is high, assert ready_inX and push that port's payload.
REQ-015 SHALL, when count<2 and both valid inputs are high, grant the port equal to prio only; the other ready SHALL be 0.
REQ-016 SHALL keep prio as a 1-bit round-robin pointer: after any accepted push from port p, prio <= ~p; with no push, prio holds.
REQ-017 SHALL push at most one entry per cycle.
REQ-018 SHALL define a pop as valid_out && ready_out.
REQ-019 SHALL drive valid_out = (count!=0) and present the head entry on the payload outputs and src_out.
REQ-020 SHALL make an accepted input visible on valid_out the next cycle when the FIFO was empty (latency 1).
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged and deliver the new entry after the remaining older entry.
REQ-022 SHALL deliver entries strictly in acceptance order, with the payload unmodified.
REQ-023 SHALL hold the output payload stable while valid_out && !ready_out.
REQ-024 SHALL sustain one response per cycle when ready_out is held high.
REQ-025 SHALL wrap the FIFO read/write pointers modulo 2.
REQ-026 SHALL never overflow or underflow: no push when count==2, no pop when count==0.
REQ-027 SHALL treat valid_inX during reset as don't-care; ready_inX SHALL be 0 while reset==0.

Reset
REQ-028 SHALL, while reset==0 at a clk edge, set count=0, both pointers=0 and prio=0.
REQ-029 SHALL hold valid_out=0, src_out=0, tag_out=0, result=0, has_fflags=0 and fflags=0 after reset.
REQ-030 SHALL discard buffered entries on reset mid-operation; none SHALL appear after reset deasserts.
REQ-031 SHALL allow the first push in the first cycle with reset==1.

Verification
REQ-032 Single: ready_out=1; valid_in0 for 1 cycle with tag=1 and result=0x3F800000 -> next cycle valid_out=1, tag_out=1, result=0x3F800000, src_out=0; following cycle valid_out=0.
REQ-033 Contention: both valid held high, ready_out=1, starting from prio=0 -> grants alternate 0,1,0,1 and src_out follows the same sequence one cycle later.
REQ-034 Backpressure: ready_out=0; three back-to-back valid_in0 -> first two accepted, ready_in0=0 on the third; payload held. Raise ready_out -> outputs arrive in order and the third is accepted the cycle after count drops.
REQ-035 Push+pop with count=1, ready_out=1, valid_in1 -> count stays 1 and order is preserved.
REQ-036 Reset mid-stream: count=2, reset=0 for 1 cycle -> valid_out=0 and all outputs 0; no stale entry is seen afterwards.
REQ-037 fflags pass-through: has_fflags_in1=1, fflags_in1=5'b01000 -> has_fflags=1 and fflags=5'b01000 on the output.

Source files
------------

// File: rtl/vx_fp_divsqrt_arb.sv
// Merges the divider (port 0) and square-root (port 1) result streams into one response
// stream through a 2-entry FIFO, with round-robin arbitration when both ports present.
module vx_fp_divsqrt_arb #(
  parameter int TAGW  = 1,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  valid_in0,
  output logic                  ready_in0,
  input  logic [TAGW-1:0]       tag_in0,
  input  logic [LANES*32-1:0]   result_in0,
  input  logic                  has_fflags_in0,
  input  logic [LANES*5-1:0]    fflags_in0,

  input  logic                  valid_in1,
  output logic                  ready_in1,
  input  logic [TAGW-1:0]       tag_in1,
  input  logic [LANES*32-1:0]   result_in1,
  input  logic                  has_fflags_in1,
  input  logic [LANES*5-1:0]    fflags_in1,

  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [TAGW-1:0]       tag_out,
  output logic [LANES*32-1:0]   result,
  output logic                  has_fflags,
  output logic [LANES*5-1:0]    fflags,
  output logic                  src_out
);

  localparam int DW = LANES * 32;
  localparam int FW = LANES * 5;
  localparam int EW = 1 + TAGW + DW + 1 + FW;

  logic [EW-1:0] mem_q [2];
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          prio_q, prio_d;

  logic          gnt0_s, gnt1_s;
  logic          push_s, pop_s;
  logic [EW-1:0] push_entry_s;
  logic [EW-1:0] head_s;

  // Grant at most one port; a full FIFO refuses pushes even if it pops this cycle.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset && (count_q != 2'd2)) begin
      gnt0_s = valid_in0 && (!valid_in1 || !prio_q);
      gnt1_s = valid_in1 && (!valid_in0 || prio_q);
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign ready_in0 = gnt0_s;
  assign ready_in1 = gnt1_s;
  assign push_s    = gnt0_s || gnt1_s;
  assign valid_out = (count_q != 2'd0);
  assign pop_s     = valid_out && ready_out;

  // Select the payload of the granted port.
  always_comb begin
    push_entry_s = {1'b0, tag_in0, result_in0, has_fflags_in0, fflags_in0};
    if (gnt1_s) begin
      push_entry_s = {1'b1, tag_in1, result_in1, has_fflags_in1, fflags_in1};
    end else begin
      push_entry_s = {1'b0, tag_in0, result_in0, has_fflags_in0, fflags_in0};
    end
  end

  // Occupancy, pointer and round-robin next state.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push_s) begin
      wr_ptr_d = ~wr_ptr_q;
      prio_d   = ~gnt1_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
      prio_d   = prio_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State and storage registers; reset drops any buffered entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      prio_q   <= 1'b0;
      mem_q[0] <= {EW{1'b0}};
      mem_q[1] <= {EW{1'b0}};
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_entry_s;
      end
    end
  end

  assign head_s = mem_q[rd_ptr_q];

  // Present the head entry; an empty FIFO shows an all-zero payload.
  always_comb begin
    {src_out, tag_out, result, has_fflags, fflags} = {EW{1'b0}};
    if (valid_out) begin
      {src_out, tag_out, result, has_fflags, fflags} = head_s;
    end else begin
      {src_out, tag_out, result, has_fflags, fflags} = {EW{1'b0}};
    end
  end

endmodule

// File: tb/tb_vx_fp_divsqrt_arb.sv
// Directed bench for vx_fp_divsqrt_arb: the stimulus pushes expected entries into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_vx_fp_divsqrt_arb;
  localparam int TAGW  = 4;
  localparam int LANES = 1;
  localparam int EW    = 1 + TAGW + 32 + 1 + 5;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, ro;
  logic [TAGW-1:0] t0, t1;
  logic [31:0] d0, d1;
  logic h0, h1;
  logic [4:0] f0, f1;
  logic r0, r1, valid_out, has_fflags, src_out;
  logic [TAGW-1:0] tag_out;
  logic [31:0] result;
  logic [4:0] fflags;

  logic [EW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_fp_divsqrt_arb #(.TAGW(TAGW), .LANES(LANES)) dut (
    .clk(clk), .reset(rst),
    .valid_in0(v0), .ready_in0(r0), .tag_in0(t0), .result_in0(d0),
    .has_fflags_in0(h0), .fflags_in0(f0),
    .valid_in1(v1), .ready_in1(r1), .tag_in1(t1), .result_in1(d1),
    .has_fflags_in1(h1), .fflags_in1(f1),
    .valid_out(valid_out), .ready_out(ro), .tag_out(tag_out), .result(result),
    .has_fflags(has_fflags), .fflags(fflags), .src_out(src_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Port 0 always carries has_fflags=1, fflags=5'b10001 so a port swap shows up.
  task automatic step(input logic a_v0, input logic [TAGW-1:0] a_t0, input logic [31:0] a_d0,
                      input logic a_v1, input logic [TAGW-1:0] a_t1, input logic [31:0] a_d1,
                      input logic a_h1, input logic [4:0] a_f1, input logic a_ro,
                      input logic e0, input logic e1, input logic evo);
    v0 = a_v0; t0 = a_t0; d0 = a_d0; h0 = 1'b1; f0 = 5'b10001;
    v1 = a_v1; t1 = a_t1; d1 = a_d1; h1 = a_h1; f1 = a_f1;
    ro = a_ro;
    #1;
    chk("ready_in0", {63'd0, r0}, {63'd0, e0});
    chk("ready_in1", {63'd0, r1}, {63'd0, e1});
    chk("valid_out", {63'd0, valid_out}, {63'd0, evo});
    if (e0) exp_q.push_back({1'b0, a_t0, a_d0, 1'b1, 5'b10001});
    if (e1) exp_q.push_back({1'b1, a_t1, a_d1, a_h1, a_f1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic a_ro, input logic evo);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, a_ro, 1'b0, 1'b0, evo);
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expected entry.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (rst === 1'b1 && valid_out === 1'b1 && ro === 1'b1) begin
      act = {src_out, tag_out, result, has_fflags, fflags};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_output: got %0h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors = errors + 1;
          $display("FAIL output_entry: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; ro = 1'b0;
    v0 = 1'b1; t0 = 4'd15; d0 = 32'hDEADBEEF; h0 = 1'b1; f0 = 5'b11111;
    v1 = 1'b1; t1 = 4'd15; d1 = 32'hDEADBEEF; h1 = 1'b1; f1 = 5'b11111;
    @(posedge clk); #1;
    chk("reset_ready_in0", {63'd0, r0}, 64'd0);
    chk("reset_ready_in1", {63'd0, r1}, 64'd0);
    @(posedge clk); #1;
    chk("reset_valid_out", {63'd0, valid_out}, 64'd0);
    chk("reset_payload", {21'd0, src_out, tag_out, result, has_fflags, fflags}, 64'd0);
    rst = 1'b1;

    // Single push, latency 1, then empty again.
    step(1'b1, 4'd1, 32'h3F800000, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Port 1 with fflags, which also leaves prio at 0.
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h40000000, 1'b1, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1);

    // Contention: grants alternate 0,1,0,1.
    step(1'b1, 4'd3, 32'h40400000, 1'b1, 4'd4, 32'h40800000, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd5, 32'h40A00000, 1'b1, 4'd6, 32'h40C00000, 1'b0, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd7, 32'h40E00000, 1'b1, 4'd6, 32'h41000000, 1'b1, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd5, 32'h41100000, 1'b1, 4'd9, 32'h41200000, 1'b1, 5'b10000, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Backpressure: two accepted, third refused while full, then drained in order.
    step(1'b1, 4'd8, 32'hAAAA0001, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd9, 32'hBBBB0002, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("hold_tag_a", {60'd0, tag_out}, 64'd8);
    step(1'b1, 4'd10, 32'hCCCC0003, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_tag_b", {60'd0, tag_out}, 64'd8);
    chk("hold_result", {32'd0, result}, 64'hAAAA0001);
    step(1'b1, 4'd10, 32'hCCCC0003, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd10, 32'hCCCC0003, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Push and pop together with one entry buffered.
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd11, 32'h11110000, 1'b0, 5'b00011, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'h22220000, 1'b1, 5'b00110, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Fill, then reset mid-stream; nothing buffered may survive.
    step(1'b1, 4'd13, 32'h33330000, 1'b0, 4'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'h44440000, 1'b1, 5'b11000, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; ro = 1'b0;
    #1;
    chk("midreset_ready_in0", {63'd0, r0}, 64'd0);
    chk("midreset_ready_in1", {63'd0, r1}, 64'd0);
    @(posedge clk); #1;
    chk("midreset_valid_out", {63'd0, valid_out}, 64'd0);
    chk("midreset_payload", {21'd0, src_out, tag_out, result, has_fflags, fflags}, 64'd0);
    exp_q.delete();
    rst = 1'b1;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
